// File: rtl/isqrt_sched_pkg.sv
// Shared widths, pipeline state type and helpers for the isqrt scheduler.
package isqrt_sched_pkg;
  localparam int ISQRT_W     = 32;
  localparam int ISQRT_RES_W = 16;
  localparam int REM_W       = ISQRT_RES_W + 2;
  localparam int MAX_REQ     = 16;

  typedef struct packed {
    logic [ISQRT_W-1:0]     x;
    logic [REM_W-1:0]       rem;
    logic [ISQRT_RES_W-1:0] root;
  } isqrt_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [31:0] id);
    return MAX_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/isqrt.sv
// Pipelined digit-by-digit integer square root; x_vld to y_vld latency is N_STAGES.
module isqrt
  import isqrt_sched_pkg::*;
#(
  parameter int N_STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x_vld,
  input  logic [ISQRT_W-1:0]     x,
  output logic                   y_vld,
  output logic [ISQRT_RES_W-1:0] y
);
  localparam int PER = (ISQRT_RES_W + N_STAGES - 1) / N_STAGES;

  function automatic isqrt_state_t sqrt_steps(input isqrt_state_t s, input int first);
    isqrt_state_t     r;
    logic [REM_W-1:0] rem_t;
    logic [REM_W-1:0] trial;
    r     = s;
    rem_t = '0;
    trial = '0;
    for (int j = 0; j < PER; j++) begin
      if (first + j < ISQRT_RES_W) begin
        rem_t = {r.rem[REM_W-3:0], r.x[ISQRT_W-1 -: 2]};
        trial = {r.root, 2'b01};
        r.x   = r.x << 2;
        if (rem_t >= trial) begin
          r.rem  = rem_t - trial;
          r.root = {r.root[ISQRT_RES_W-2:0], 1'b1};
        end else begin
          r.rem  = rem_t;
          r.root = {r.root[ISQRT_RES_W-2:0], 1'b0};
        end
      end
    end
    return r;
  endfunction

  function automatic logic [ISQRT_RES_W-1:0] sqrt_root(input isqrt_state_t s, input int first);
    isqrt_state_t r;
    r = sqrt_steps(s, first);
    return r.root;
  endfunction

  logic [N_STAGES-1:0] vld_reg;
  isqrt_state_t        st_reg [N_STAGES];

  // Each register holds the state entering its iteration group; the last group feeds y directly.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
    logic         src_vld;
    isqrt_state_t src_st;
    if (gi == 0) begin : g_in
      assign src_vld = x_vld;
      assign src_st  = {x, {REM_W{1'b0}}, {ISQRT_RES_W{1'b0}}};
    end else begin : g_mid
      assign src_vld = vld_reg[gi-1];
      assign src_st  = sqrt_steps(st_reg[gi-1], (gi - 1) * PER);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_reg[gi] <= 1'b0;
      else     vld_reg[gi] <= src_vld;
    end

    always_ff @(posedge clk) begin
      if (src_vld) st_reg[gi] <= src_st;
    end
  end

  assign y_vld = vld_reg[N_STAGES-1];
  assign y     = sqrt_root(st_reg[N_STAGES-1], (N_STAGES - 1) * PER);
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);
  // Scan from the farthest candidate back towards ptr so the nearest eligible one wins.
  always_comb begin
    logic [ID_W:0] cand;
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (eligible[cand[ID_W-1:0]]) begin
        grant                 = '0;
        grant[cand[ID_W-1:0]] = 1'b1;
        grant_idx             = cand[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/shift_register_with_valid.sv
// Valid-qualified delay line; payload registers only load when their input is valid.
module shift_register_with_valid #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] vld_reg;
  logic [W-1:0]     data_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic         src_vld;
    logic [W-1:0] src_data;
    if (gi == 0) begin : g_in
      assign src_vld  = in_vld;
      assign src_data = in_data;
    end else begin : g_mid
      assign src_vld  = vld_reg[gi-1];
      assign src_data = data_reg[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_reg[gi] <= 1'b0;
      else        vld_reg[gi] <= src_vld;
    end

    always_ff @(posedge clk) begin
      if (src_vld) data_reg[gi] <= src_data;
    end
  end

  assign out_vld  = vld_reg[DEPTH-1];
  assign out_data = data_reg[DEPTH-1];
endmodule

// File: rtl/isqrt_rr_scheduler.sv
// Shares one pipelined isqrt among N_REQ requesters with round-robin issue and tagged return.
module isqrt_rr_scheduler
  import isqrt_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int N_PIPE_STAGES = 4,
  parameter int MAX_OUT       = 3,
  parameter int ID_W          = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ*ISQRT_W-1:0] req_x,
  output logic [N_REQ-1:0]         req_rdy,
  output logic [N_REQ-1:0]         rsp_vld,
  output logic [ISQRT_RES_W-1:0]   rsp_y,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]        ptr_reg;
  logic [CNT_W-1:0]       cnt_reg [N_REQ];
  logic [N_REQ-1:0]       eligible, grant, dec, cnt_nz;
  logic [ID_W-1:0]        grant_idx;
  logic                   accept;
  logic [ISQRT_W-1:0]     req_x_arr [N_REQ];
  logic [ISQRT_W-1:0]     x_q;
  logic [ID_W-1:0]        id_q, tag_id;
  logic                   vld_q, tag_vld, y_vld, isqrt_rst;
  logic [ISQRT_RES_W-1:0] y;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic inc;
    assign req_x_arr[gi] = req_x[gi*ISQRT_W +: ISQRT_W];
    assign eligible[gi]  = req_vld[gi] && (cnt_reg[gi] < CNT_W'(MAX_OUT));
    assign inc           = accept && grant[gi];
    assign cnt_nz[gi]    = (cnt_reg[gi] != '0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   cnt_reg[gi] <= '0;
      else if (inc && !dec[gi])   cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      else if (dec[gi] && !inc)   cnt_reg[gi] <= cnt_reg[gi] - CNT_W'(1);
    end

    a_cnt_max: assert property (@(posedge clk) disable iff (!rst)
      (inc && !dec[gi]) |-> (cnt_reg[gi] < CNT_W'(MAX_OUT)));
    a_cnt_min: assert property (@(posedge clk) disable iff (!rst)
      (dec[gi] && !inc) |-> (cnt_reg[gi] != '0));
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are masked while reset is held so nothing looks accepted during reset.
  assign req_rdy = grant & {N_REQ{rst}};
  assign accept  = |req_rdy;
  assign busy    = |cnt_nz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      x_q     <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        ptr_reg <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        id_q    <= grant_idx;
        x_q     <= req_x_arr[grant_idx];
      end
    end
  end

  assign isqrt_rst = ~rst;

  isqrt #(.N_STAGES(N_PIPE_STAGES)) u_isqrt (
    .clk   (clk),
    .rst   (isqrt_rst),
    .x_vld (vld_q),
    .x     (x_q),
    .y_vld (y_vld),
    .y     (y)
  );

  shift_register_with_valid #(.W(ID_W), .DEPTH(N_PIPE_STAGES)) u_tag (
    .clk      (clk),
    .rst_n    (rst),
    .in_vld   (vld_q),
    .in_data  (id_q),
    .out_vld  (tag_vld),
    .out_data (tag_id)
  );

  a_tag_match: assert property (@(posedge clk) disable iff (!rst) y_vld == tag_vld);

  assign dec = y_vld ? N_REQ'(onehot(32'(tag_id))) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld <= '0;
      rsp_y   <= '0;
      rsp_id  <= '0;
    end else begin
      rsp_vld <= dec;
      if (y_vld) begin
        rsp_y  <= y;
        rsp_id <= tag_id;
      end
    end
  end
endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
// Directed bench for isqrt_rr_scheduler with default parameters (4 requesters, 4 stages, MAX_OUT=3).
module tb_isqrt_rr_scheduler;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_vld = '0;
  logic [127:0] req_x = '0;
  logic [3:0]   req_rdy, rsp_vld;
  logic [15:0]  rsp_y;
  logic [1:0]   rsp_id;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int toggles = 0;
  logic mon_en = 1'b0;

  int          b_id [3] = '{0, 3, 1};
  logic [31:0] b_x  [3] = '{32'd0, 32'd1, 32'hFFFF_FFFF};
  int          b_y  [3] = '{0, 1, 65535};

  isqrt_rr_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_x   (req_x),
    .req_rdy (req_rdy),
    .rsp_vld (rsp_vld),
    .rsp_y   (rsp_y),
    .rsp_id  (rsp_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(dut.x_q or rsp_y or rsp_id) begin
    if (mon_en) toggles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    req_x[i*32 +: 32] = v;
  endtask

  initial begin
    // Reset state, with all requests raised to show req_rdy stays low in reset
    repeat (2) step();
    req_vld = 4'hF;
    #1;
    chk("rst_rdy", 32'(req_rdy), 32'h0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("rst_rsp_y", 32'(rsp_y), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    req_vld = 4'h0;
    step();
    rst = 1'b1;
    step();

    // Single operation: requester 2, x=144
    set_x(2, 32'd144);
    req_vld = 4'b0100;
    #1;
    chk("single_rdy", 32'(req_rdy), 32'h4);
    step();
    req_vld = 4'h0;
    chk("single_busy", 32'(busy), 32'h1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("single_early", 32'(rsp_vld), 32'h0);
    end
    step();
    chk("single_rsp_vld", 32'(rsp_vld), 32'h4);
    chk("single_rsp_y", 32'(rsp_y), 32'd12);
    chk("single_rsp_id", 32'(rsp_id), 32'd2);
    $display("single: x=144 y=%0d id=%0d", rsp_y, rsp_id);
    step();
    chk("single_busy_end", 32'(busy), 32'h0);
    chk("single_rsp_drop", 32'(rsp_vld), 32'h0);

    // Fairness from ptr=0: reset, then all four requesters stream x_i=i*i+i
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_x(i, 32'(i * i + i));
    req_vld = 4'hF;
    for (int k = 0; k < 18; k++) begin
      if (k == 12) req_vld = 4'h0;
      #1;
      chk("fair_rdy", 32'(req_rdy), (k < 12) ? 32'(1 << (k % 4)) : 32'h0);
      if (k >= 6) begin
        chk("fair_rsp_vld", 32'(rsp_vld), 32'(1 << ((k - 6) % 4)));
        chk("fair_rsp_y", 32'(rsp_y), 32'((k - 6) % 4));
        chk("fair_rsp_id", 32'(rsp_id), 32'((k - 6) % 4));
        $display("fair: cycle=%0d rsp_id=%0d rsp_y=%0d", k, rsp_id, rsp_y);
      end else begin
        chk("fair_rsp_idle", 32'(rsp_vld), 32'h0);
      end
      step();
    end
    chk("fair_drained", 32'(rsp_vld), 32'h0);
    chk("fair_busy_end", 32'(busy), 32'h0);

    // Outstanding limit: requester 1 holds req_vld, x=25
    set_x(1, 32'd25);
    req_vld = 4'b0010;
    for (int k = 0; k < 18; k++) begin
      if (k == 12) req_vld = 4'h0;
      #1;
      chk("limit_rdy", 32'(req_rdy), (k < 12 && (k % 6) < 3) ? 32'h2 : 32'h0);
      chk("limit_rsp_vld", 32'(rsp_vld), (k >= 6 && (k % 6) < 3) ? 32'h2 : 32'h0);
      if (k >= 6 && (k % 6) < 3) begin
        chk("limit_rsp_y", 32'(rsp_y), 32'd5);
        chk("limit_rsp_id", 32'(rsp_id), 32'd1);
      end
      $display("limit: cycle=%0d req_rdy=%b rsp_vld=%b", k, req_rdy, rsp_vld);
      step();
    end
    chk("limit_busy_end", 32'(busy), 32'h0);

    // Boundary operands on consecutive cycles from requesters 0, 3, 1
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin
        set_x(b_id[k], b_x[k]);
        req_vld = 4'(1 << b_id[k]);
      end else begin
        req_vld = 4'h0;
      end
      #1;
      if (k < 3) chk("bound_rdy", 32'(req_rdy), 32'(1 << b_id[k]));
      if (k >= 6 && k < 9) begin
        chk("bound_rsp_vld", 32'(rsp_vld), 32'(1 << b_id[k-6]));
        chk("bound_rsp_y", 32'(rsp_y), 32'(b_y[k-6]));
        chk("bound_rsp_id", 32'(rsp_id), 32'(b_id[k-6]));
        $display("bound: x=%0h y=%0d id=%0d", b_x[k-6], rsp_y, rsp_id);
      end else begin
        chk("bound_rsp_idle", 32'(rsp_vld), 32'h0);
      end
      step();
    end

    // Reset mid-flight: three accepts from requester 2, reset pulse two cycles later
    set_x(2, 32'd100);
    req_vld = 4'b0100;
    step();
    step();
    step();
    req_vld = 4'h0;
    #1;
    chk("mid_busy_before", 32'(busy), 32'h1);
    step();
    rst = 1'b0;
    req_vld = 4'hF;
    #1;
    chk("mid_rst_rdy", 32'(req_rdy), 32'h0);
    chk("mid_rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("mid_rst_rsp_y", 32'(rsp_y), 32'h0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b1;
    req_vld = 4'h0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("mid_discarded", 32'(rsp_vld), 32'h0);
      step();
    end
    set_x(3, 32'd81);
    req_vld = 4'b1000;
    #1;
    chk("mid_new_rdy", 32'(req_rdy), 32'h8);
    step();
    req_vld = 4'h0;
    for (int k = 1; k < 6; k++) begin
      chk("mid_new_early", 32'(rsp_vld), 32'h0);
      step();
    end
    chk("mid_new_rsp_vld", 32'(rsp_vld), 32'h8);
    chk("mid_new_rsp_y", 32'(rsp_y), 32'd9);
    chk("mid_new_rsp_id", 32'(rsp_id), 32'd3);
    $display("mid: x=81 y=%0d id=%0d", rsp_y, rsp_id);

    // Idle: 20 cycles without requests, nothing may toggle
    mon_en = 1'b1;
    repeat (20) step();
    mon_en = 1'b0;
    chk("idle_toggles", 32'(toggles), 32'h0);
    chk("idle_x_q", dut.x_q, 32'd81);
    chk("idle_rsp_y", 32'(rsp_y), 32'd9);
    chk("idle_rsp_id", 32'(rsp_id), 32'd3);
    chk("idle_rsp_vld", 32'(rsp_vld), 32'h0);
    $display("idle: toggles=%0d x_q=%0d", toggles, dut.x_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
